flash_bus_ctrl: RTL and testbench

- Parametrised successor to the U409 flash control stub; drives the parallel boot/config flash from the 68040 local bus.
- Decodes a flash-space cycle on TSn and latches address and direction.
- Sequences read and write strobes with programmable wait states, generates a power-on flash reset pulse and write-protect gating, then returns a one-cycle F_ACK to the bus terminator logic in U409.

---
 rtl/flash_bus_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_flash_bus_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_bus_ctrl.sv
// flash_bus_ctrl: 68040 local-bus controller for the parallel boot/config flash.
// Decodes a flash-space cycle, sequences read/write strobes with programmable
// wait states, holds the flash in reset after power-on, gates write protect and
// returns a one-cycle acknowledge to the bus terminator.
// Optional build macro: FLASH_RDY_POLL_EN adds F_RDY polling with a timeout
// after every write (and before reads while the flash reports busy).
`timescale 1ns/1ps
module flash_bus_ctrl #(
  parameter int ADDR_W      = 23,
  parameter int RD_WAIT     = 4,
  parameter int WR_SETUP    = 1,
  parameter int WR_PULSE    = 3,
  parameter int WR_HOLD     = 1,
  parameter int RST_CYCLES  = 20,
  parameter int RDY_TIMEOUT = 1024
) (
  input  logic            i_clk40,
  input  logic            i_reset,
  input  logic            i_tsn,
  input  logic            i_rnw,
  input  logic            i_flash_space,
  input  logic [ADDR_W:1] i_a,
  input  logic            i_wp_unlock,
  input  logic            i_f_rdy,
  output logic [ADDR_W:1] o_f_a,
  output logic            o_f_enn,
  output logic            o_f_wpn,
  output logic            o_f_readn,
  output logic            o_f_writen,
  output logic            o_f_rstn,
  output logic            o_f_ack,
  output logic            o_wr_denied,
  output logic            o_timeout
);

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  localparam int MAX_P = max2(max2(max2(RD_WAIT, WR_SETUP), max2(WR_PULSE, WR_HOLD)),
                              max2(RST_CYCLES, RDY_TIMEOUT));
  localparam int CW = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_RST = CW'(RST_CYCLES);
  localparam logic [CW-1:0] C_RD  = CW'(RD_WAIT);
  localparam logic [CW-1:0] C_WS  = CW'(WR_SETUP);
  localparam logic [CW-1:0] C_WP  = CW'(WR_PULSE);
  localparam logic [CW-1:0] C_WH  = CW'(WR_HOLD);
`ifdef FLASH_RDY_POLL_EN
  localparam logic [CW-1:0] C_TO  = CW'(RDY_TIMEOUT);
`endif

  typedef enum logic [2:0] {
    RSTP = 3'd0,
    IDLE = 3'd1,
    RD   = 3'd2,
    WS   = 3'd3,
    WP   = 3'd4,
    WH   = 3'd5,
    BUSY = 3'd6,
    ACK  = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_next_cnt;
  logic            w_latch;
  logic            w_set_denied;
  logic [ADDR_W:1] r_f_a;
  logic            r_wr_denied;
  logic            r_f_enn;
  logic            r_f_readn;
  logic            r_f_writen;
  logic            r_f_rstn;
  logic            r_f_wpn;
  logic            r_f_ack;
  logic            w_next_enn;
  logic            w_next_readn;
  logic            w_next_writen;
  logic            w_next_rstn;
  logic            w_next_wpn;
  logic            w_next_ack;

`ifdef FLASH_RDY_POLL_EN
  logic r_rdy_meta;
  logic r_rdy_sync;
  logic r_rnw;
  logic r_timeout;
  logic w_set_timeout;

  // Double-flop the asynchronous F_RDY into the CLK40 domain.
  always_ff @(posedge i_clk40 or posedge i_reset) begin
    if (i_reset) begin
      r_rdy_meta <= 1'b0;
      r_rdy_sync <= 1'b0;
    end else begin
      r_rdy_meta <= i_f_rdy;
      r_rdy_sync <= r_rdy_meta;
    end
  end

  // Remember the cycle direction (BUSY must know whether a read follows) and the sticky timeout.
  always_ff @(posedge i_clk40 or posedge i_reset) begin
    if (i_reset) begin
      r_rnw     <= 1'b1;
      r_timeout <= 1'b0;
    end else begin
      if (w_latch) begin
        r_rnw <= i_rnw;
      end
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_timeout = r_timeout;
`else
  logic w_unused_rdy;
  assign w_unused_rdy = i_f_rdy;
  assign o_timeout    = 1'b0;
`endif

  // Next-state and counter reload: each timed state loads its count on entry and exits when the count reaches 1.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt - C_ONE;
    w_latch      = 1'b0;
    w_set_denied = 1'b0;
`ifdef FLASH_RDY_POLL_EN
    w_set_timeout = 1'b0;
`endif
    case (r_state)
      RSTP: begin
        if (r_cnt == C_ONE) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = RSTP;
        end
      end
      IDLE: begin
        w_next_cnt = r_cnt;
        if (!i_tsn && i_flash_space) begin
          w_latch = 1'b1;
          if (i_rnw) begin
`ifdef FLASH_RDY_POLL_EN
            if (!r_rdy_sync) begin
              w_next_state = BUSY;
              w_next_cnt   = C_TO;
            end else begin
              w_next_state = RD;
              w_next_cnt   = C_RD;
            end
`else
            w_next_state = RD;
            w_next_cnt   = C_RD;
`endif
          end else if (i_wp_unlock) begin
            w_next_state = WS;
            w_next_cnt   = C_WS;
          end else begin
            // Locked write: drop it, flag it, still terminate the bus cycle.
            w_next_state = ACK;
            w_set_denied = 1'b1;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      RD: begin
        if (r_cnt == C_ONE) begin
          w_next_state = ACK;
        end else begin
          w_next_state = RD;
        end
      end
      WS: begin
        if (r_cnt == C_ONE) begin
          w_next_state = WP;
          w_next_cnt   = C_WP;
        end else begin
          w_next_state = WS;
        end
      end
      WP: begin
        if (r_cnt == C_ONE) begin
          w_next_state = WH;
          w_next_cnt   = C_WH;
        end else begin
          w_next_state = WP;
        end
      end
      WH: begin
        if (r_cnt == C_ONE) begin
`ifdef FLASH_RDY_POLL_EN
          w_next_state = BUSY;
          w_next_cnt   = C_TO;
`else
          w_next_state = ACK;
`endif
        end else begin
          w_next_state = WH;
        end
      end
`ifdef FLASH_RDY_POLL_EN
      BUSY: begin
        if (r_rdy_sync) begin
          w_next_state = r_rnw ? RD : ACK;
          w_next_cnt   = C_RD;
        end else if (r_cnt == C_ONE) begin
          // Flash never reported ready: flag it and finish the cycle anyway.
          w_set_timeout = 1'b1;
          w_next_state  = r_rnw ? RD : ACK;
          w_next_cnt    = C_RD;
        end else begin
          w_next_state = BUSY;
        end
      end
`endif
      ACK: begin
        w_next_state = IDLE;
        w_next_cnt   = r_cnt;
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = r_cnt;
      end
    endcase
  end

  // Strobe decode from the next state so the registered outputs line up with the state register.
  always_comb begin
    w_next_enn    = !((w_next_state == RD) || (w_next_state == WS) ||
                      (w_next_state == WP) || (w_next_state == WH));
    w_next_readn  = (w_next_state != RD);
    w_next_writen = (w_next_state != WP);
    w_next_rstn   = (w_next_state != RSTP);
    w_next_ack    = (w_next_state == ACK);
    w_next_wpn    = (w_next_state == RSTP) ? 1'b0 : i_wp_unlock;
  end

  // State, counter, latched address, sticky denial flag and registered strobes.
  always_ff @(posedge i_clk40 or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= RSTP;
      r_cnt       <= C_RST;
      r_f_a       <= {ADDR_W{1'b0}};
      r_wr_denied <= 1'b0;
      r_f_enn     <= 1'b1;
      r_f_readn   <= 1'b1;
      r_f_writen  <= 1'b1;
      r_f_rstn    <= 1'b0;
      r_f_wpn     <= 1'b0;
      r_f_ack     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      if (w_latch) begin
        r_f_a <= i_a;
      end
      if (w_set_denied) begin
        r_wr_denied <= 1'b1;
      end
      r_f_enn    <= w_next_enn;
      r_f_readn  <= w_next_readn;
      r_f_writen <= w_next_writen;
      r_f_rstn   <= w_next_rstn;
      r_f_wpn    <= w_next_wpn;
      r_f_ack    <= w_next_ack;
    end
  end

  assign o_f_a       = r_f_a;
  assign o_f_enn     = r_f_enn;
  assign o_f_readn   = r_f_readn;
  assign o_f_writen  = r_f_writen;
  assign o_f_rstn    = r_f_rstn;
  assign o_f_wpn     = r_f_wpn;
  assign o_f_ack     = r_f_ack;
  assign o_wr_denied = r_wr_denied;

endmodule

// File: tb/tb_flash_bus_ctrl.sv
// Directed self-checking bench for flash_bus_ctrl (default parameters,
// RDY_TIMEOUT reduced to 16 so the polling scenarios stay short).
`timescale 1ns/1ps
module tb_flash_bus_ctrl;
  localparam int AW = 23;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tsn = 1'b1;
  logic          rnw = 1'b1;
  logic          fs = 1'b0;
  logic [AW:1]   a = {AW{1'b0}};
  logic          wp_unlock = 1'b1;
  logic          f_rdy = 1'b1;
  logic [AW:1]   f_a;
  logic          f_enn, f_wpn, f_readn, f_writen, f_rstn, f_ack, wr_denied, timeout;

  int errors = 0;
  int checks = 0;

  flash_bus_ctrl #(.ADDR_W(AW), .RD_WAIT(4), .WR_SETUP(1), .WR_PULSE(3), .WR_HOLD(1),
                   .RST_CYCLES(20), .RDY_TIMEOUT(16)) dut (
    .i_clk40(clk), .i_reset(reset), .i_tsn(tsn), .i_rnw(rnw), .i_flash_space(fs),
    .i_a(a), .i_wp_unlock(wp_unlock), .i_f_rdy(f_rdy),
    .o_f_a(f_a), .o_f_enn(f_enn), .o_f_wpn(f_wpn), .o_f_readn(f_readn),
    .o_f_writen(f_writen), .o_f_rstn(f_rstn), .o_f_ack(f_ack),
    .o_wr_denied(wr_denied), .o_timeout(timeout)
  );

  always #12 clk = ~clk;

  task automatic test_reset();
    logic [5:0] exp6;
    reset = 1'b1; wp_unlock = 1'b1;
    repeat (2) @(negedge clk);
    exp6 = 6'b111000;
    checks++;
    if ({f_enn, f_readn, f_writen, f_rstn, f_wpn, f_ack} !== exp6) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", {f_enn, f_readn, f_writen, f_rstn, f_wpn, f_ack}, exp6);
    end
    checks++;
    if ({f_a, wr_denied, timeout} !== {{AW{1'b0}}, 2'b00}) begin
      errors++;
      $display("FAIL reset_regs: got f_a=%h den=%b to=%b expected 0", f_a, wr_denied, timeout);
    end
    reset = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      checks++;
      if (f_rstn !== ((k >= 20) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL rstp_rstn k=%0d: got %b expected %b", k, f_rstn, (k >= 20) ? 1'b1 : 1'b0);
      end
      checks++;
      if ({f_enn, f_readn, f_writen, f_ack} !== 4'b1110) begin
        errors++;
        $display("FAIL rstp_quiet k=%0d: got %b expected 1110", k, {f_enn, f_readn, f_writen, f_ack});
      end
      if (k == 10) begin
        checks++;
        if (f_wpn !== 1'b0) begin
          errors++;
          $display("FAIL rstp_wpn: got %b expected 0", f_wpn);
        end
      end
      if (k == 22) begin
        checks++;
        if (f_wpn !== 1'b1) begin
          errors++;
          $display("FAIL idle_wpn: got %b expected 1", f_wpn);
        end
      end
      // A flash-space read attempt in the middle of RSTP must be ignored.
      if (k == 5) begin
        tsn = 1'b0; fs = 1'b1; rnw = 1'b1; a = 23'h00ABC;
      end else begin
        tsn = 1'b1; fs = 1'b0;
      end
    end
  endtask

  task automatic test_read();
    logic [3:0] exp4;
    tsn = 1'b0; rnw = 1'b1; fs = 1'b1; a = 23'h01234;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp4 = (c <= 4) ? 4'b0010 : ((c == 5) ? 4'b1111 : 4'b1110);
      checks++;
      if ({f_enn, f_readn, f_writen, f_ack} !== exp4) begin
        errors++;
        $display("FAIL read c=%0d: got enn/readn/writen/ack=%b expected %b", c, {f_enn, f_readn, f_writen, f_ack}, exp4);
      end
      if (c == 1 || c == 6) begin
        checks++;
        if (f_a !== 23'h01234) begin
          errors++;
          $display("FAIL read_addr c=%0d: got %h expected 001234", c, f_a);
        end
      end
      if (c == 1) begin
        tsn = 1'b1; fs = 1'b0; a = 23'h7FFFFF;
      end
    end
  endtask

  task automatic test_write_unlocked();
    logic [3:0] exp4;
    wp_unlock = 1'b1;
    tsn = 1'b0; rnw = 1'b0; fs = 1'b1; a = 23'h2AAAA;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      exp4 = {(c <= 5) ? 1'b0 : 1'b1, 1'b1, (c >= 2 && c <= 4) ? 1'b0 : 1'b1, (c == 6) ? 1'b1 : 1'b0};
      checks++;
      if ({f_enn, f_readn, f_writen, f_ack} !== exp4) begin
        errors++;
        $display("FAIL write c=%0d: got enn/readn/writen/ack=%b expected %b", c, {f_enn, f_readn, f_writen, f_ack}, exp4);
      end
      if (c == 1) begin
        checks++;
        if (f_a !== 23'h2AAAA) begin
          errors++;
          $display("FAIL write_addr: got %h expected 02aaaa", f_a);
        end
        tsn = 1'b1; fs = 1'b0; rnw = 1'b1;
      end
    end
  endtask

  task automatic test_write_denied();
    logic [3:0] exp4;
    wp_unlock = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({f_wpn, wr_denied} !== 2'b00) begin
      errors++;
      $display("FAIL locked_pre: got wpn/denied=%b expected 00", {f_wpn, wr_denied});
    end
    tsn = 1'b0; rnw = 1'b0; fs = 1'b1; a = 23'h00F0F;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp4 = (c == 1) ? 4'b1111 : 4'b1110;
      checks++;
      if ({f_enn, f_readn, f_writen, f_ack} !== exp4) begin
        errors++;
        $display("FAIL denied c=%0d: got enn/readn/writen/ack=%b expected %b", c, {f_enn, f_readn, f_writen, f_ack}, exp4);
      end
      checks++;
      if (wr_denied !== 1'b1) begin
        errors++;
        $display("FAIL denied_sticky c=%0d: got %b expected 1", c, wr_denied);
      end
      if (c == 1) begin
        checks++;
        if (f_a !== 23'h00F0F) begin
          errors++;
          $display("FAIL denied_addr: got %h expected 000f0f", f_a);
        end
        tsn = 1'b1; fs = 1'b0; rnw = 1'b1;
      end
    end
    wp_unlock = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_no_decode();
    tsn = 1'b0; fs = 1'b0; rnw = 1'b1; a = 23'h00777;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if ({f_enn, f_readn, f_writen, f_ack} !== 4'b1110) begin
        errors++;
        $display("FAIL no_decode c=%0d: got %b expected 1110", c, {f_enn, f_readn, f_writen, f_ack});
      end
    end
    tsn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp4;
    int acks;
    acks = 0;
    tsn = 1'b0; rnw = 1'b1; fs = 1'b1; a = 23'h00055;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 5 || c == 11) exp4 = 4'b1111;
      else if (c == 6 || c == 12) exp4 = 4'b1110;
      else exp4 = 4'b0010;
      checks++;
      if ({f_enn, f_readn, f_writen, f_ack} !== exp4) begin
        errors++;
        $display("FAIL b2b c=%0d: got enn/readn/writen/ack=%b expected %b", c, {f_enn, f_readn, f_writen, f_ack}, exp4);
      end
      if (f_ack === 1'b1) acks++;
      if (c == 7) begin
        tsn = 1'b1; fs = 1'b0;
      end
    end
    checks++;
    if (acks !== 2) begin
      errors++;
      $display("FAIL b2b_ack_count: got %0d expected 2", acks);
    end
  endtask

`ifdef FLASH_RDY_POLL_EN
  task automatic test_rdy_poll();
    logic [3:0] exp4;
    f_rdy = 1'b0;
    repeat (3) @(negedge clk);
    tsn = 1'b0; rnw = 1'b0; fs = 1'b1; a = 23'h00100;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      exp4 = {(c <= 5) ? 1'b0 : 1'b1, 1'b1, (c >= 2 && c <= 4) ? 1'b0 : 1'b1, (c == 13) ? 1'b1 : 1'b0};
      checks++;
      if ({f_enn, f_readn, f_writen, f_ack} !== exp4) begin
        errors++;
        $display("FAIL rdy_poll c=%0d: got %b expected %b", c, {f_enn, f_readn, f_writen, f_ack}, exp4);
      end
      if (c == 1) begin
        tsn = 1'b1; fs = 1'b0; rnw = 1'b1;
      end
      if (c == 10) f_rdy = 1'b1;
    end
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL rdy_no_timeout: got %b expected 0", timeout);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp4;
    f_rdy = 1'b0;
    repeat (3) @(negedge clk);
    tsn = 1'b0; rnw = 1'b0; fs = 1'b1; a = 23'h00200;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      exp4 = {(c <= 5) ? 1'b0 : 1'b1, 1'b1, (c >= 2 && c <= 4) ? 1'b0 : 1'b1, (c == 22) ? 1'b1 : 1'b0};
      checks++;
      if ({f_enn, f_readn, f_writen, f_ack} !== exp4) begin
        errors++;
        $display("FAIL timeout_seq c=%0d: got %b expected %b", c, {f_enn, f_readn, f_writen, f_ack}, exp4);
      end
      checks++;
      if (timeout !== ((c >= 22) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL timeout_flag c=%0d: got %b expected %b", c, timeout, (c >= 22) ? 1'b1 : 1'b0);
      end
      if (c == 1) begin
        tsn = 1'b1; fs = 1'b0; rnw = 1'b1;
      end
    end
    f_rdy = 1'b1;
    repeat (3) @(negedge clk);
  endtask
`else
  task automatic test_timeout_tied();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_tied: got %b expected 0", timeout);
    end
  endtask
`endif

  task automatic test_reset_mid_write();
    wp_unlock = 1'b1;
    tsn = 1'b0; rnw = 1'b0; fs = 1'b1; a = 23'h03333;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tsn = 1'b1; fs = 1'b0; rnw = 1'b1;
      end
    end
    checks++;
    if ({f_enn, f_writen} !== 2'b00) begin
      errors++;
      $display("FAIL mid_write_wp: got enn/writen=%b expected 00", {f_enn, f_writen});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({f_enn, f_readn, f_writen, f_ack, f_rstn} !== 5'b11100) begin
      errors++;
      $display("FAIL async_abort: got enn/readn/writen/ack/rstn=%b expected 11100", {f_enn, f_readn, f_writen, f_ack, f_rstn});
    end
    checks++;
    if (wr_denied !== 1'b0) begin
      errors++;
      $display("FAIL denied_cleared: got %b expected 0", wr_denied);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      checks++;
      if ({f_ack, f_enn, f_writen} !== 3'b011) begin
        errors++;
        $display("FAIL abort_quiet k=%0d: got ack/enn/writen=%b expected 011", k, {f_ack, f_enn, f_writen});
      end
      checks++;
      if (f_rstn !== ((k >= 20) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL restart_rstn k=%0d: got %b expected %b", k, f_rstn, (k >= 20) ? 1'b1 : 1'b0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_unlocked();
    test_write_denied();
    test_no_decode();
    test_back_to_back();
`ifdef FLASH_RDY_POLL_EN
    test_rdy_poll();
    test_timeout();
`else
    test_timeout_tied();
`endif
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
